// File: rtl/scarv_cop_vtx_tracer.sv
// -----------------------------------------------------------------------------
// scarv_cop_vtx_tracer
//
// Passive tracer for the CPU <-> COP instruction interface. It watches the
// request and response handshakes. For every retired COP instruction it emits
// one trace record, marked by a single-cycle vtx_valid pulse. The record
// carries the encoding, the rs1 value, the response fields, and COP register
// file snapshots taken before and after the instruction.
//
// Optional feature (compile-time macro SCARV_COP_VTX_TIMEOUT_EN):
//   When defined, a WAIT_RSP cycle counter forces an ABORT record after
//   TIMEOUT cycles with no response. When undefined, no counter exists and
//   the tracer waits for the response indefinitely.
//
// Ports:
//   g_clk, g_resetn                  clock, async active-low reset
//   cpu_insn_req_valid/_ack          observed request handshake
//   cpu_insn_enc, cpu_rs1            request fields (sampled on handshake)
//   cop_insn_rsp_valid/_ack          observed response handshake
//   cop_insn_rsp, cop_wdata,
//   cop_waddr, cop_wen               response fields (sampled on handshake)
//   cop_cprs                         live COP register file, reg i at [32i+:32]
//   vtx_*                            trace record outputs, valid on vtx_valid
//   trc_err                          sticky protocol-violation flag
// -----------------------------------------------------------------------------
module scarv_cop_vtx_tracer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         cpu_insn_req_valid,
  input  logic         cpu_insn_req_ack,
  input  logic [31:0]  cpu_insn_enc,
  input  logic [31:0]  cpu_rs1,
  input  logic         cop_insn_rsp_valid,
  input  logic         cop_insn_rsp_ack,
  input  logic [2:0]   cop_insn_rsp,
  input  logic [31:0]  cop_wdata,
  input  logic [4:0]   cop_waddr,
  input  logic         cop_wen,
  input  logic [511:0] cop_cprs,
  output logic         vtx_valid,
  output logic         vtx_reset,
  output logic [31:0]  vtx_instr_enc,
  output logic [31:0]  vtx_instr_rs1,
  output logic [2:0]   vtx_instr_result,
  output logic [31:0]  vtx_instr_wdata,
  output logic [4:0]   vtx_instr_waddr,
  output logic         vtx_instr_wen,
  output logic [511:0] vtx_cprs_pre,
  output logic [511:0] vtx_cprs_post,
  output logic         trc_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  localparam logic [2:0] INSN_ABORT = 3'b001;

  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("scarv_cop_vtx_tracer: TIMEOUT must be at least 1");
  end

  logic req_hs;
  logic rsp_hs;
  assign req_hs = cpu_insn_req_valid && cpu_insn_req_ack;
  assign rsp_hs = cop_insn_rsp_valid && cop_insn_rsp_ack;

  // In-flight instruction latches
  logic [1:0]   state_q,  state_d;
  logic [31:0]  enc_q,    enc_d;
  logic [31:0]  rs1_q,    rs1_d;
  logic [511:0] pre_q,    pre_d;
  logic [2:0]   rsp_q,    rsp_d;
  logic [31:0]  wdata_q,  wdata_d;
  logic [4:0]   waddr_q,  waddr_d;
  logic         wen_q,    wen_d;

  // Record outputs and flags
  logic         vvalid_q, vvalid_d;
  logic         vreset_q;
  logic         err_q,    err_d;
  logic [31:0]  o_enc_q,   o_enc_d;
  logic [31:0]  o_rs1_q,   o_rs1_d;
  logic [2:0]   o_rsp_q,   o_rsp_d;
  logic [31:0]  o_wdata_q, o_wdata_d;
  logic [4:0]   o_waddr_q, o_waddr_d;
  logic         o_wen_q,   o_wen_d;
  logic [511:0] o_pre_q,   o_pre_d;
  logic [511:0] o_post_q,  o_post_d;

`ifdef SCARV_COP_VTX_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    enc_d     = enc_q;
    rs1_d     = rs1_q;
    pre_d     = pre_q;
    rsp_d     = rsp_q;
    wdata_d   = wdata_q;
    waddr_d   = waddr_q;
    wen_d     = wen_q;
    err_d     = err_q;
    vvalid_d  = 1'b0;
    o_enc_d   = o_enc_q;
    o_rs1_d   = o_rs1_q;
    o_rsp_d   = o_rsp_q;
    o_wdata_d = o_wdata_q;
    o_waddr_d = o_waddr_q;
    o_wen_d   = o_wen_q;
    o_pre_d   = o_pre_q;
    o_post_d  = o_post_q;
`ifdef SCARV_COP_VTX_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif

    case (state_q)
      // EMIT publishes the record. It then accepts a new request exactly as
      // IDLE does, so back-to-back instructions lose no cycle.
      S_IDLE, S_EMIT: begin
        if (state_q == S_EMIT) begin
          vvalid_d  = 1'b1;
          o_enc_d   = enc_q;
          o_rs1_d   = rs1_q;
          o_rsp_d   = rsp_q;
          o_wdata_d = wdata_q;
          o_waddr_d = waddr_q;
          o_wen_d   = wen_q;
          o_pre_d   = pre_q;
          o_post_d  = cop_cprs;
        end
        state_d = S_IDLE;
        if (req_hs) begin
          enc_d   = cpu_insn_enc;
          rs1_d   = cpu_rs1;
          pre_d   = cop_cprs;
          state_d = S_WAIT;
`ifdef SCARV_COP_VTX_TIMEOUT_EN
          tmo_d   = '0;
`endif
          // A zero-latency COP answers in the same cycle it is asked.
          if (rsp_hs) begin
            rsp_d   = cop_insn_rsp;
            wdata_d = cop_wdata;
            waddr_d = cop_waddr;
            wen_d   = cop_wen;
            state_d = S_EMIT;
          end
        end else if (rsp_hs) begin
          // A response with no outstanding request is a protocol violation.
          err_d = 1'b1;
        end
      end

      S_WAIT: begin
        // A second request while one is outstanding is flagged and dropped.
        if (req_hs) begin
          err_d = 1'b1;
        end
        if (rsp_hs) begin
          rsp_d   = cop_insn_rsp;
          wdata_d = cop_wdata;
          waddr_d = cop_waddr;
          wen_d   = cop_wen;
          state_d = S_EMIT;
        end
`ifdef SCARV_COP_VTX_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          rsp_d   = INSN_ABORT;
          wdata_d = '0;
          waddr_d = '0;
          wen_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_EMIT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the wide snapshot registers are ordinary flops, not memories, so
  // they are reset along with everything else. This way no stale record can
  // leak out after reset.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q   <= S_IDLE;
      enc_q     <= '0;
      rs1_q     <= '0;
      pre_q     <= '0;
      rsp_q     <= '0;
      wdata_q   <= '0;
      waddr_q   <= '0;
      wen_q     <= 1'b0;
      err_q     <= 1'b0;
      vvalid_q  <= 1'b0;
      vreset_q  <= 1'b1;
      o_enc_q   <= '0;
      o_rs1_q   <= '0;
      o_rsp_q   <= '0;
      o_wdata_q <= '0;
      o_waddr_q <= '0;
      o_wen_q   <= 1'b0;
      o_pre_q   <= '0;
      o_post_q  <= '0;
`ifdef SCARV_COP_VTX_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // values. EMIT relies on this: it publishes the old latches in the
      // same edge that it overwrites them with a new request.
      state_q   <= state_d;
      enc_q     <= enc_d;
      rs1_q     <= rs1_d;
      pre_q     <= pre_d;
      rsp_q     <= rsp_d;
      wdata_q   <= wdata_d;
      waddr_q   <= waddr_d;
      wen_q     <= wen_d;
      err_q     <= err_d;
      vvalid_q  <= vvalid_d;
      // vtx_reset holds 1 through the first edge after release, then drops.
      vreset_q  <= 1'b0;
      o_enc_q   <= o_enc_d;
      o_rs1_q   <= o_rs1_d;
      o_rsp_q   <= o_rsp_d;
      o_wdata_q <= o_wdata_d;
      o_waddr_q <= o_waddr_d;
      o_wen_q   <= o_wen_d;
      o_pre_q   <= o_pre_d;
      o_post_q  <= o_post_d;
`ifdef SCARV_COP_VTX_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign vtx_valid        = vvalid_q;
  assign vtx_reset        = vreset_q;
  assign vtx_instr_enc    = o_enc_q;
  assign vtx_instr_rs1    = o_rs1_q;
  assign vtx_instr_result = o_rsp_q;
  assign vtx_instr_wdata  = o_wdata_q;
  assign vtx_instr_waddr  = o_waddr_q;
  assign vtx_instr_wen    = o_wen_q;
  assign vtx_cprs_pre     = o_pre_q;
  assign vtx_cprs_post    = o_post_q;
  assign trc_err          = err_q;

endmodule

// File: tb/tb_scarv_cop_vtx_tracer.sv
// -----------------------------------------------------------------------------
// tb_scarv_cop_vtx_tracer
//
// Directed self-checking bench for scarv_cop_vtx_tracer. Each scenario task
// drives the bus and checks the outputs against hand-computed values.
// Inputs change 1 ns after a rising edge, and outputs are sampled there too.
// The timeout scenario runs only when SCARV_COP_VTX_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_scarv_cop_vtx_tracer;

  logic         clk;
  logic         rst_n;
  logic         req_valid, req_ack;
  logic [31:0]  enc, rs1;
  logic         rsp_valid, rsp_ack;
  logic [2:0]   rsp;
  logic [31:0]  wdata;
  logic [4:0]   waddr;
  logic         wen;
  logic [511:0] cprs;

  logic         vtx_valid, vtx_reset;
  logic [31:0]  vtx_instr_enc, vtx_instr_rs1, vtx_instr_wdata;
  logic [2:0]   vtx_instr_result;
  logic [4:0]   vtx_instr_waddr;
  logic         vtx_instr_wen;
  logic [511:0] vtx_cprs_pre, vtx_cprs_post;
  logic         trc_err;

  int checks = 0;
  int errors = 0;

  scarv_cop_vtx_tracer #(.TIMEOUT(8)) dut (
    .g_clk              (clk),
    .g_resetn           (rst_n),
    .cpu_insn_req_valid (req_valid),
    .cpu_insn_req_ack   (req_ack),
    .cpu_insn_enc       (enc),
    .cpu_rs1            (rs1),
    .cop_insn_rsp_valid (rsp_valid),
    .cop_insn_rsp_ack   (rsp_ack),
    .cop_insn_rsp       (rsp),
    .cop_wdata          (wdata),
    .cop_waddr          (waddr),
    .cop_wen            (wen),
    .cop_cprs           (cprs),
    .vtx_valid          (vtx_valid),
    .vtx_reset          (vtx_reset),
    .vtx_instr_enc      (vtx_instr_enc),
    .vtx_instr_rs1      (vtx_instr_rs1),
    .vtx_instr_result   (vtx_instr_result),
    .vtx_instr_wdata    (vtx_instr_wdata),
    .vtx_instr_waddr    (vtx_instr_waddr),
    .vtx_instr_wen      (vtx_instr_wen),
    .vtx_cprs_pre       (vtx_cprs_pre),
    .vtx_cprs_post      (vtx_cprs_post),
    .trc_err            (trc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] e, input logic [31:0] r);
    req_valid = 1'b1; req_ack = 1'b1; enc = e; rs1 = r;
  endtask

  task automatic drive_rsp(input logic [2:0] res, input logic [31:0] wd,
                           input logic [4:0] wa, input logic we);
    rsp_valid = 1'b1; rsp_ack = 1'b1; rsp = res; wdata = wd; waddr = wa; wen = we;
  endtask

  task automatic clear_bus();
    req_valid = 1'b0; req_ack = 1'b0; rsp_valid = 1'b0; rsp_ack = 1'b0;
  endtask

  task automatic test_reset();
    clear_bus();
    enc = '0; rs1 = '0; rsp = '0; wdata = '0; waddr = '0; wen = 1'b0; cprs = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick(); tick();
    checks++; if (vtx_reset !== 1'b1) begin errors++; $display("FAIL rst_vtx_reset_in_reset got %b exp 1", vtx_reset); end
    checks++; if (vtx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", vtx_valid); end
    checks++; if (trc_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", trc_err); end
    checks++; if (vtx_instr_enc !== 32'h0) begin errors++; $display("FAIL rst_enc got %h exp 0", vtx_instr_enc); end
    checks++; if (vtx_cprs_post !== 512'h0) begin errors++; $display("FAIL rst_post nonzero got %h", vtx_cprs_post[31:0]); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (vtx_reset !== 1'b1) begin errors++; $display("FAIL rst_vtx_reset_before_edge got %b exp 1", vtx_reset); end
    tick();
    checks++; if (vtx_reset !== 1'b0) begin errors++; $display("FAIL rst_vtx_reset_after_edge got %b exp 0", vtx_reset); end
    checks++; if (vtx_valid !== 1'b0 || trc_err !== 1'b0) begin errors++; $display("FAIL rst_idle_bus got valid %b err %b exp 0 0", vtx_valid, trc_err); end
  endtask

  task automatic test_single();
    cprs[0 +: 32] = 32'h0000_0011;
    drive_req(32'h0000_102B, 32'hDEAD_BEEF);
    tick();
    clear_bus();
    tick(); tick();
    checks++; if (vtx_valid !== 1'b0) begin errors++; $display("FAIL single_wait_valid got %b exp 0", vtx_valid); end
    drive_rsp(3'b000, 32'h0000_1234, 5'd7, 1'b0);
    cprs[3*32 +: 32] = 32'hDEAD_BEEF;
    tick();
    clear_bus();
    checks++; if (vtx_valid !== 1'b0) begin errors++; $display("FAIL single_latency_early got %b exp 0", vtx_valid); end
    tick();
    checks++; if (vtx_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", vtx_valid); end
    checks++; if (vtx_instr_enc !== 32'h0000_102B) begin errors++; $display("FAIL single_enc got %h exp 0000102b", vtx_instr_enc); end
    checks++; if (vtx_instr_rs1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rs1 got %h exp deadbeef", vtx_instr_rs1); end
    checks++; if (vtx_instr_result !== 3'b000) begin errors++; $display("FAIL single_result got %h exp 0", vtx_instr_result); end
    checks++; if (vtx_instr_wen !== 1'b0) begin errors++; $display("FAIL single_wen got %b exp 0", vtx_instr_wen); end
    checks++; if (vtx_instr_wdata !== 32'h0000_1234 || vtx_instr_waddr !== 5'd7) begin errors++; $display("FAIL single_wfields got %h/%0d exp 00001234/7", vtx_instr_wdata, vtx_instr_waddr); end
    checks++; if (vtx_cprs_pre[3*32 +: 32] !== 32'h0) begin errors++; $display("FAIL single_pre3 got %h exp 0", vtx_cprs_pre[3*32 +: 32]); end
    checks++; if (vtx_cprs_pre[0 +: 32] !== 32'h11) begin errors++; $display("FAIL single_pre0 got %h exp 11", vtx_cprs_pre[0 +: 32]); end
    checks++; if (vtx_cprs_post[3*32 +: 32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_post3 got %h exp deadbeef", vtx_cprs_post[3*32 +: 32]); end
    tick();
    checks++; if (vtx_valid !== 1'b0) begin errors++; $display("FAIL single_one_pulse got %b exp 0", vtx_valid); end
    checks++; if (vtx_instr_enc !== 32'h0000_102B) begin errors++; $display("FAIL single_hold_enc got %h exp 0000102b", vtx_instr_enc); end
    checks++; if (trc_err !== 1'b0) begin errors++; $display("FAIL single_err got %b exp 0", trc_err); end
  endtask

  task automatic test_back_to_back();
    logic [511:0] post_a;
    drive_req(32'h0000_0111, 32'h0000_0001);
    tick();
    clear_bus();
    drive_rsp(3'b000, 32'h0, 5'd0, 1'b0);
    cprs[5*32 +: 32] = 32'hAAAA_0005;
    post_a = cprs;
    tick();
    clear_bus();
    drive_req(32'h0000_0222, 32'h0000_0002);
    tick();
    clear_bus();
    checks++; if (vtx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_a got %b exp 1", vtx_valid); end
    checks++; if (vtx_instr_enc !== 32'h0000_0111) begin errors++; $display("FAIL b2b_enc_a got %h exp 00000111", vtx_instr_enc); end
    checks++; if (vtx_cprs_post !== post_a) begin errors++; $display("FAIL b2b_post_a got %h exp %h", vtx_cprs_post, post_a); end
    drive_rsp(3'b010, 32'h0000_00AB, 5'd3, 1'b1);
    cprs[6*32 +: 32] = 32'hBBBB_0006;
    tick();
    clear_bus();
    checks++; if (vtx_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b exp 0", vtx_valid); end
    tick();
    checks++; if (vtx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_b got %b exp 1", vtx_valid); end
    checks++; if (vtx_instr_enc !== 32'h0000_0222 || vtx_instr_rs1 !== 32'h2) begin errors++; $display("FAIL b2b_req_b got %h/%h exp 00000222/00000002", vtx_instr_enc, vtx_instr_rs1); end
    checks++; if (vtx_instr_result !== 3'b010 || vtx_instr_wen !== 1'b1) begin errors++; $display("FAIL b2b_rsp_b got %h/%b exp 2/1", vtx_instr_result, vtx_instr_wen); end
    checks++; if (vtx_cprs_pre !== post_a) begin errors++; $display("FAIL b2b_pre_b got %h exp %h", vtx_cprs_pre, post_a); end
    checks++; if (vtx_cprs_post[6*32 +: 32] !== 32'hBBBB_0006) begin errors++; $display("FAIL b2b_post_b got %h exp bbbb0006", vtx_cprs_post[6*32 +: 32]); end
    checks++; if (trc_err !== 1'b0) begin errors++; $display("FAIL b2b_err got %b exp 0", trc_err); end
    tick();
  endtask

  task automatic test_wait_err();
    drive_req(32'h0000_0333, 32'h0000_0003);
    tick();
    clear_bus();
    drive_req(32'h0000_0444, 32'h0000_0004);
    tick();
    clear_bus();
    checks++; if (trc_err !== 1'b1) begin errors++; $display("FAIL werr_set got %b exp 1", trc_err); end
    checks++; if (vtx_valid !== 1'b0) begin errors++; $display("FAIL werr_valid got %b exp 0", vtx_valid); end
    drive_rsp(3'b000, 32'h0000_0055, 5'd9, 1'b1);
    tick();
    clear_bus();
    tick();
    checks++; if (vtx_valid !== 1'b1) begin errors++; $display("FAIL werr_emit got %b exp 1", vtx_valid); end
    checks++; if (vtx_instr_enc !== 32'h0000_0333 || vtx_instr_rs1 !== 32'h3) begin errors++; $display("FAIL werr_first_kept got %h/%h exp 00000333/00000003", vtx_instr_enc, vtx_instr_rs1); end
    checks++; if (vtx_instr_wdata !== 32'h55 || vtx_instr_waddr !== 5'd9 || vtx_instr_wen !== 1'b1) begin errors++; $display("FAIL werr_wfields got %h/%0d/%b exp 00000055/9/1", vtx_instr_wdata, vtx_instr_waddr, vtx_instr_wen); end
    tick();
    checks++; if (trc_err !== 1'b1 || vtx_valid !== 1'b0) begin errors++; $display("FAIL werr_sticky got err %b valid %b exp 1 0", trc_err, vtx_valid); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    drive_req(32'h0000_0555, 32'h0000_0005);
    tick();
    clear_bus();
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (vtx_valid !== 1'b0 || trc_err !== 1'b0 || vtx_reset !== 1'b1) begin errors++; $display("FAIL rmid_async got valid %b err %b rst %b exp 0 0 1", vtx_valid, trc_err, vtx_reset); end
    checks++; if (vtx_instr_enc !== 32'h0 || vtx_cprs_pre !== 512'h0) begin errors++; $display("FAIL rmid_cleared got enc %h", vtx_instr_enc); end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    drive_rsp(3'b000, 32'h0, 5'd0, 1'b0);
    tick();
    clear_bus();
    checks++; if (trc_err !== 1'b1) begin errors++; $display("FAIL rmid_err got %b exp 1", trc_err); end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (vtx_valid === 1'b1) seen = 1'b1;
      tick();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_no_record got %b exp 0", seen); end
  endtask

`ifdef SCARV_COP_VTX_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive_req(32'h0000_0666, 32'h0000_0006);
    tick();
    clear_bus();
    n = 0;
    while (vtx_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++; if (n !== 9) begin errors++; $display("FAIL tmo_latency got %0d exp 9", n); end
    checks++; if (vtx_instr_result !== 3'b001 || vtx_instr_wen !== 1'b0) begin errors++; $display("FAIL tmo_abort got %h/%b exp 1/0", vtx_instr_result, vtx_instr_wen); end
    checks++; if (vtx_instr_wdata !== 32'h0 || vtx_instr_waddr !== 5'd0) begin errors++; $display("FAIL tmo_wfields got %h/%0d exp 0/0", vtx_instr_wdata, vtx_instr_waddr); end
    checks++; if (trc_err !== 1'b1 || vtx_instr_enc !== 32'h0000_0666) begin errors++; $display("FAIL tmo_err_enc got %b/%h exp 1/00000666", trc_err, vtx_instr_enc); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wait_err();
    test_reset_mid();
`ifdef SCARV_COP_VTX_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scarv_cop_vtx_tracer.md
SCARV_COP_VTX_TRACER -- requirements
Module: scarv_cop_vtx_tracer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, cycles waited for a response before forced abort (used only when the timeout feature is compiled in).
REQ-002 SHALL have g_clk  input  1  the only clock; all state SHALL update on the rising edge.
REQ-003 SHALL have g_resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have cpu_insn_req_valid / cpu_insn_req_ack  input  1 each  observed CPU-to-COP request handshake; the tracer is passive and drives neither.
REQ-005 SHALL have cpu_insn_enc  input  32  instruction encoding, and cpu_rs1  input  32  GPR rs1 value, both sampled on request handshake.
REQ-006 SHALL have cop_insn_rsp_valid / cop_insn_rsp_ack  input  1 each  observed COP-to-CPU response handshake.
REQ-007 SHALL have cop_insn_rsp (3), cop_wdata (32), cop_waddr (5), cop_wen (1)  inputs  response fields, sampled on response handshake.
REQ-008 SHALL have cop_cprs  input  512  live COP register file, flattened, reg i at bits [32i+31:32i].
REQ-009 SHALL have outputs vtx_valid 1, vtx_reset 1, vtx_instr_enc 32, vtx_instr_rs1 32, vtx_instr_result 3, vtx_instr_wdata 32, vtx_instr_waddr 5, vtx_instr_wen 1, vtx_cprs_pre 512, vtx_cprs_post 512: one retired-instruction trace record per vtx_valid pulse.
REQ-010 SHALL have trc_err  output  1  sticky protocol-violation flag.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT_RSP, EMIT.
REQ-012 IDLE: on request handshake (valid&&ack), SHALL latch enc, rs1 and cop_cprs (as pre snapshot) and go to WAIT_RSP.
REQ-013 WAIT_RSP: on response handshake, SHALL latch response fields and go to EMIT.
REQ-014 EMIT: SHALL latch cop_cprs as post snapshot, drive all vtx_* record outputs from latches, assert vtx_valid for exactly this one cycle.
REQ-015 Latency: vtx_valid SHALL assert exactly 2 cycles after the cycle containing the response handshake (latch cycle, then EMIT cycle output registered).
REQ-016 EMIT with a simultaneous request handshake SHALL latch the new request/pre snapshot and go directly to WAIT_RSP; otherwise go to IDLE.
REQ-017 Request and response handshakes in the same IDLE cycle (zero-latency COP) SHALL be latched together and go directly to EMIT.
REQ-018 A request handshake in WAIT_RSP, or a response handshake in IDLE without a same-cycle request, SHALL set trc_err, be ignored, and leave state unchanged.
REQ-019 vtx_* record outputs SHALL hold their last values when vtx_valid is low.

Reset
REQ-020 While g_resetn low: state IDLE, vtx_valid 0, trc_err 0, all record outputs and snapshots 0, vtx_reset 1.
REQ-021 vtx_reset SHALL remain 1 for the first g_clk edge after g_resetn rises, then 0.
REQ-022 Reset asserted mid-instruction (WAIT_RSP/EMIT) SHALL discard the partial record; no vtx_valid SHALL be produced for it.

Configuration
REQ-023 Macro SCARV_COP_VTX_TIMEOUT_EN: when defined, a counter SHALL count WAIT_RSP cycles; reaching TIMEOUT SHALL force EMIT with vtx_instr_result = SCARV_COP_INSN_ABORT, vtx_instr_wen 0, wdata 0, waddr 0, and set trc_err.
REQ-024 Without SCARV_COP_VTX_TIMEOUT_EN no counter SHALL exist and WAIT_RSP SHALL wait indefinitely.

Verification
REQ-025 Reset release, idle bus -> vtx_reset 1 for first edge then 0; vtx_valid 0, trc_err 0.
REQ-026 Request enc 0x0000_102B, rs1 0xDEAD_BEEF, cprs[3]=0; response 3 cycles later, rsp SUCCESS, COP writes cprs[3]=0xDEAD_BEEF -> single vtx_valid 2 cycles after response, pre[3]=0, post[3]=0xDEAD_BEEF, rs1 0xDEAD_BEEF, wen 0.
REQ-027 Back-to-back: second request during EMIT -> two vtx_valid pulses, second record carries second enc and pre equal to first record's post.
REQ-028 Second request while in WAIT_RSP -> trc_err 1 and stays 1; first record emitted unchanged.
REQ-029 g_resetn pulled low in WAIT_RSP, then released, response arrives -> no vtx_valid; trc_err 1 (response in IDLE).
REQ-030 With SCARV_COP_VTX_TIMEOUT_EN, TIMEOUT=8, no response -> vtx_valid after 8 WAIT_RSP cycles, result ABORT, wen 0, trc_err 1.
